// File: rtl/impl_chk_pkg.sv
// Shared helpers for the multi-channel implication window checker:
// saturating add, popcount and parameter validation.
package impl_chk_pkg;

    localparam int unsigned MAX_CNT_W = 32;
    localparam int unsigned MAX_WIN   = 64;

    function automatic logic [MAX_CNT_W-1:0] sat_add(
        input logic [MAX_CNT_W-1:0] cnt,
        input logic [MAX_CNT_W-1:0] inc,
        input int                   width
    );
        logic [MAX_CNT_W:0] sum;
        logic [MAX_CNT_W:0] limit;
        sum   = {1'b0, cnt} + {1'b0, inc};
        limit = '0;
        for (int i = 0; i < MAX_CNT_W; i++) begin
            limit[i] = (i < width);
        end
        return (sum > limit) ? limit[MAX_CNT_W-1:0] : sum[MAX_CNT_W-1:0];
    endfunction

    function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_WIN-1:0] mask);
        logic [MAX_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_WIN; i++) begin
            n = n + MAX_CNT_W'(mask[i]);
        end
        return n;
    endfunction

    // The window must be non-empty, start at or after 0 and fit the popcount mask.
    function automatic bit params_valid(input int nch, input int min_dly,
                                        input int max_dly, input int cnt_w);
        return (nch > 0) && (min_dly >= 0) && (max_dly >= 1) && (max_dly >= min_dly) &&
               (max_dly < MAX_WIN) && (cnt_w >= 1) && (cnt_w <= MAX_CNT_W);
    endfunction

endpackage

// File: rtl/impl_chk_chan.sv
// One channel of the checker: pending-attempt shift vector, pass/fail
// resolution against the [MIN_DLY:MAX_DLY] window, and saturating counters.
module impl_chk_chan
    import impl_chk_pkg::*;
#(
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             a_i,
    input  logic             b_i,
    output logic             pass_pulse_o,
    output logic             fail_pulse_o,
    output logic             fail_now_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o
);

    logic [MAX_DLY:1] pend_q, pend_d;
    logic [MAX_DLY:0] age;
    logic [MAX_DLY:0] passVec;
    logic             failNow;
    logic             passPulse_q, passPulse_d;
    logic             failPulse_q, failPulse_d;
    logic [CNT_W-1:0] passCnt_q, passCnt_d;
    logic [CNT_W-1:0] failCnt_q, failCnt_d;

    // age[0] is the attempt launched this edge; every attempt inside the window passes on b.
    always_comb begin
        age     = {pend_q, a_i};
        passVec = '0;
        for (int k = 0; k <= MAX_DLY; k++) begin
            passVec[k] = b_i && age[k] && (k >= MIN_DLY);
        end
        failNow = age[MAX_DLY] && !passVec[MAX_DLY];

        pend_d      = '0;
        passPulse_d = 1'b0;
        failPulse_d = 1'b0;
        passCnt_d   = '0;
        failCnt_d   = '0;
        if (!clr_i) begin
            pend_d      = age[MAX_DLY-1:0] & ~passVec[MAX_DLY-1:0];
            passPulse_d = |passVec;
            failPulse_d = failNow;
            passCnt_d   = CNT_W'(sat_add(MAX_CNT_W'(passCnt_q),
                                         popcount(MAX_WIN'(passVec)), CNT_W));
            failCnt_d   = CNT_W'(sat_add(MAX_CNT_W'(failCnt_q),
                                         MAX_CNT_W'(failNow), CNT_W));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q      <= '0;
            passPulse_q <= 1'b0;
            failPulse_q <= 1'b0;
            passCnt_q   <= '0;
            failCnt_q   <= '0;
        end else begin
            pend_q      <= pend_d;
            passPulse_q <= passPulse_d;
            failPulse_q <= failPulse_d;
            passCnt_q   <= passCnt_d;
            failCnt_q   <= failCnt_d;
        end
    end

    assign fail_now_o   = failNow && !clr_i;
    assign pass_pulse_o = passPulse_q;
    assign fail_pulse_o = failPulse_q;
    assign pass_cnt_o   = passCnt_q;
    assign fail_cnt_o   = failCnt_q;

endmodule

// File: rtl/impl_window_checker.sv
// Multi-channel "a |-> ##[MIN_DLY:MAX_DLY] b" checker with sticky error flag.
// Define IMPL_CHK_FIRST_FAIL_LOG_EN to add the first-fail channel/timestamp logger.
module impl_window_checker
    import impl_chk_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 3,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [NCH-1:0]       a,
    input  logic [NCH-1:0]       b,
    output logic [NCH-1:0]       pass_pulse,
    output logic [NCH-1:0]       fail_pulse,
    output logic [NCH*CNT_W-1:0] pass_cnt,
    output logic [NCH*CNT_W-1:0] fail_cnt,
    output logic                 err_sticky
`ifdef IMPL_CHK_FIRST_FAIL_LOG_EN
    ,
    output logic                 first_fail_vld,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] first_fail_ch,
    output logic [31:0]          first_fail_time
`endif
);

    if (!params_valid(NCH, MIN_DLY, MAX_DLY, CNT_W)) begin : g_bad_params
        $error("impl_window_checker: invalid NCH/MIN_DLY/MAX_DLY/CNT_W combination");
    end

    logic [NCH-1:0] failNow;
    logic           err_q, err_d;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        impl_chk_chan #(
            .MIN_DLY(MIN_DLY),
            .MAX_DLY(MAX_DLY),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .clr_i       (clr),
            .a_i         (a[i]),
            .b_i         (b[i]),
            .pass_pulse_o(pass_pulse[i]),
            .fail_pulse_o(fail_pulse[i]),
            .fail_now_o  (failNow[i]),
            .pass_cnt_o  (pass_cnt[i*CNT_W +: CNT_W]),
            .fail_cnt_o  (fail_cnt[i*CNT_W +: CNT_W])
        );
    end

    always_comb begin
        err_d = clr ? 1'b0 : (err_q | (|failNow));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;

`ifdef IMPL_CHK_FIRST_FAIL_LOG_EN
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [31:0]     cycle_q;
    logic            ffVld_q, ffVld_d;
    logic [CH_W-1:0] ffCh_q, ffCh_d;
    logic [31:0]     ffTime_q, ffTime_d;

    // Scanning downwards lets the lowest failing channel win a tie.
    always_comb begin
        ffVld_d  = ffVld_q;
        ffCh_d   = ffCh_q;
        ffTime_d = ffTime_q;
        if (clr) begin
            ffVld_d  = 1'b0;
            ffCh_d   = '0;
            ffTime_d = '0;
        end else if (!ffVld_q && (|failNow)) begin
            ffVld_d  = 1'b1;
            ffTime_d = cycle_q;
            for (int i = NCH - 1; i >= 0; i--) begin
                if (failNow[i]) begin
                    ffCh_d = CH_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q  <= '0;
            ffVld_q  <= 1'b0;
            ffCh_q   <= '0;
            ffTime_q <= '0;
        end else begin
            cycle_q  <= cycle_q + 32'd1;
            ffVld_q  <= ffVld_d;
            ffCh_q   <= ffCh_d;
            ffTime_q <= ffTime_d;
        end
    end

    assign first_fail_vld  = ffVld_q;
    assign first_fail_ch   = ffCh_q;
    assign first_fail_time = ffTime_q;
`endif

endmodule

// File: doc/impl_window_checker.md
Name: impl_window_checker

Overview:
- Synthesisable, multi-channel implication checker. Per channel it evaluates "a |-> ##[MIN_DLY:MAX_DLY] b" with any number of overlapping attempts in flight.
- Parametrised successor of the single-property non-overlapped `a |=> b` check. With MIN_DLY=MAX_DLY=1 it matches that semantic.
- Sits beside DUT logic as an on-chip or bench monitor.
- Reports per-attempt pass/fail pulses, saturating counters and a sticky error flag.

Parameters:
- NCH, 4, number of independent channels.
- MIN_DLY, 1, earliest cycle after the antecedent at which b may satisfy it (0 = overlapped).
- MAX_DLY, 3, last cycle at which b may satisfy it; must be ≥ max(MIN_DLY, 1).
- CNT_W, 16, width of each pass/fail counter.

Ports:
- clk  in  1  sampling clock; all inputs are sampled on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of pending attempts, counters and the sticky flag.
- a  in  NCH  antecedent per channel.
- b  in  NCH  consequent per channel.
- pass_pulse  out  NCH  one-cycle pulse: at least one attempt passed.
- fail_pulse  out  NCH  one-cycle pulse: an attempt expired without b.
- pass_cnt  out  NCH*CNT_W  per-channel count of passed attempts; channel i occupies bits [i*CNT_W +: CNT_W].
- fail_cnt  out  NCH*CNT_W  per-channel count of failed attempts; same packing.
- err_sticky  out  1  set on any fail, held until clr or reset.

Behaviour:
- Reset: rst_n low asynchronously clears all pending state. Outputs during and after reset: pass_pulse=0, fail_pulse=0, counters=0, err_sticky=0.
- Reset mid-operation: in-flight attempts are discarded and never reported.
- Per channel, a pending vector pend[1..MAX_DLY] is kept. pend[k]=1 means an attempt started k cycles ago is still unresolved.
- At each edge t, form age[0]=a(t) and age[k]=pend[k] for k=1..MAX_DLY.
- Pass resolution: if b(t)=1, every age[k] with MIN_DLY ≤ k ≤ MAX_DLY resolves as pass. This gives independent first-match per attempt.
- Fail resolution: if age[MAX_DLY]=1 and it did not pass, it resolves as fail.
- Update: next pend[k+1] = age[k] & ~resolved[k] for k < MAX_DLY.
- Overlapped case: when MIN_DLY=0, a(t)&b(t) passes in the same evaluation.
- Latency: results of the evaluation at edge t appear on the registered outputs after edge t, i.e. visible during cycle t+1.
- pass_pulse: 1 if ≥1 attempt passed.
- pass_cnt: increments by the popcount of passed attempts and saturates at 2^CNT_W−1.
- fail_pulse / fail_cnt: at most one fail per channel per cycle, so fail_cnt increments by 1. It saturates.
- Simultaneous pass and fail on one channel cannot occur: the age[MAX_DLY] attempt passes whenever b=1.
- A new attempt while older ones are pending is tracked independently; there is no merging.
- a held high for N cycles creates N attempts.
- clr has priority over the evaluation in the same cycle. Pending, counters and err_sticky become 0, and the pulses are 0 next cycle. Inputs sampled in the clr cycle are ignored.
- err_sticky: set when any fail_pulse would assert, held until clr or reset.
- Elaboration: invalid parameters (MAX_DLY < MIN_DLY, MAX_DLY = 0, NCH = 0) cause an elaboration error.

Optional Feature:
- Macro: IMPL_CHK_FIRST_FAIL_LOG_EN.
- When defined: adds outputs first_fail_vld (1 bit), first_fail_ch ($clog2(NCH) bits, min 1) and first_fail_time (32 bits).
  - A free-running 32-bit cycle counter, reset to 0 and wrapping, is captured on the first fail after reset/clr.
  - On a tie, the lowest channel index wins.
  - The captured values hold until clr or reset.
- When not defined: these ports and the timestamp counter are absent. All other behaviour is identical.

Decomposition:
- Package impl_chk_pkg:
  - function sat_add(cnt, inc), width-generic via CNT_W;
  - popcount function for pend-window masks;
  - localparam checks for MIN_DLY/MAX_DLY validity.
- Sub-module impl_chk_chan: one channel's pend vector, resolution logic and counters. The top generates NCH instances and owns err_sticky plus the optional first-fail logger.

Test Plan:
- Defaults with NCH=1, MIN=MAX=1. a=1,b=0 at one negedge, then b=1 at the next negedge -> pass_pulse=1 one cycle after b is sampled, pass_cnt=1, err_sticky=0.
- Same setup, a=1 then b held 0 -> fail_pulse=1 one cycle after the MAX_DLY edge, fail_cnt=1, err_sticky=1. Then clr=1 for one cycle -> fail_cnt=0, err_sticky=0.
- MIN=1, MAX=3, a high 3 consecutive cycles, b pulsed once 3 cycles after the first a -> all 3 attempts pass in one cycle, pass_cnt increments by 3.
- MIN=0, MAX=2, a=b=1 on the same edge on channel 2 only -> pass_pulse=4'b0100, no activity on other channels.
- CNT_W=2, five failing attempts -> fail_cnt saturates at 3. rst_n pulsed low with attempts pending -> all outputs 0 and no late pulse.
- IMPL_CHK_FIRST_FAIL_LOG_EN defined, channels 1 and 3 fail on the same edge at cycle 20 -> first_fail_vld=1, ch=1, time=20. A later fail on channel 0 leaves them unchanged.
